// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-port request/response bundle for the ALU arbiter
interface alu_arbiter_if;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][2:0]   req_funct;
   logic [1:0][63:0]  req_a;
   logic [1:0][63:0]  req_b;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [63:0]       rsp_result;
   logic [5:0]        rsp_flags;

   modport master (
      output req_valid, req_funct, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flags
   );

   modport slave (
      input  req_valid, req_funct, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flags
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two ports
module alu_arbiter #(
   parameter int RR_INIT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_arbiter_if.slave bus,
   output logic [2:0]  alu_funct,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   input  logic [63:0] alu_result,
   input  logic [5:0]  alu_flags,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state;
   state_t state_next;
   logic   prio;
   logic   grant;
   logic   grant_q;
   logic   accept;
   logic   done;

   // Lone requester wins; on contention the port holding priority wins
   always_comb begin
      grant = prio;
      if (bus.req_valid == 2'b01) begin
         grant = 1'b0;
      end else if (bus.req_valid == 2'b10) begin
         grant = 1'b1;
      end
   end

   assign accept = (state == IDLE) && (bus.req_valid != 2'b00);
   assign done   = (state == RESP) && bus.rsp_ready[grant_q];

   // State register; reset drops any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: one cycle in EXEC, hold RESP until the granted port consumes
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state and the latched grant
   always_comb begin
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
      busy          = (state != IDLE);
      if (accept) begin
         bus.req_ready = grant ? 2'b10 : 2'b01;
      end
      if (state == RESP) begin
         bus.rsp_valid = grant_q ? 2'b10 : 2'b01;
      end
   end

   // Operand latch, result capture and priority rotation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_funct      <= 3'd0;
         alu_a          <= 64'd0;
         alu_b          <= 64'd0;
         grant_q        <= 1'b0;
         bus.rsp_result <= 64'd0;
         bus.rsp_flags  <= 6'd0;
         prio           <= (RR_INIT != 0);
      end else begin
         if (accept) begin
            alu_funct <= bus.req_funct[grant];
            alu_a     <= bus.req_a[grant];
            alu_b     <= bus.req_b[grant];
            grant_q   <= grant;
         end
         if (state == EXEC) begin
            bus.rsp_result <= alu_result;
            bus.rsp_flags  <= alu_flags;
         end
         if (done) begin
            prio <= ~grant_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  alu_funct;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [63:0] alu_result;
   logic [5:0]  alu_flags;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int m_prio   = 0;

   alu_arbiter_if bus ();

   alu_arbiter #(.RR_INIT(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_funct  (alu_funct),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {flags, result}, flags = {ovf, neg, zero, eq, gt, lt}
   function automatic logic [69:0] alu_fn(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      logic        ov;
      r  = 64'd0;
      ov = 1'b0;
      case (f)
         3'd0: r = a;
         3'd1: begin r = a + b; ov = (a[63] == b[63]) && (r[63] != a[63]); end
         3'd2: begin r = a - b; ov = (a[63] != b[63]) && (r[63] != a[63]); end
         3'd3: r = a & b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin r = a + 64'd1; ov = !a[63] && r[63]; end
         default: r = 64'd0;
      endcase
      if (f == 3'd7) return 70'd0;
      return {ov, r[63], r == 64'd0, a == b, !r[63] && (r != 64'd0), r[63], r};
   endfunction

   always_comb {alu_flags, alu_result} = alu_fn(alu_funct, alu_a, alu_b);

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 7))
         0: return 64'h8000_0000_0000_0000;
         1: return 64'h7FFF_FFFF_FFFF_FFFF;
         2: return 64'd0;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      bus.req_funct = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_prio = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, bus.rsp_valid, bus.req_ready, bus.rsp_flags, alu_funct} !== 14'd0) begin
         failures++;
         $display("FAIL reset_ctrl got=%h exp=0", {busy, bus.rsp_valid, bus.req_ready, bus.rsp_flags, alu_funct});
      end
      checks++;
      if ({bus.rsp_result, alu_a, alu_b} !== 192'd0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h exp=0", bus.rsp_result, alu_a, alu_b);
      end
      rst_n = 1'b1;
      m_prio = 0;
      bus.req_valid   = 2'b10;
      bus.req_funct[1] = 3'd6;
      bus.req_a[1]     = 64'd41;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10) begin
         failures++;
         $display("FAIL first_accept got=%b exp=10", bus.req_ready);
      end
      next_cycle();
      bus.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if ({busy, bus.rsp_valid} !== 3'b100) begin
         failures++;
         $display("FAIL latency_n1 got=%b exp=100", {busy, bus.rsp_valid});
      end
      next_cycle();
      bus.rsp_ready = 2'b10;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 64'd42) begin
         failures++;
         $display("FAIL inc_resp got=%b/%0d exp=10/42", bus.rsp_valid, bus.rsp_result);
      end
      next_cycle();
      bus.rsp_ready = 2'b00;
      m_prio = 0;
   endtask

   task automatic test_single_op();
      bus.req_valid    = 2'b01;
      bus.req_funct[0] = 3'd1;
      bus.req_a[0]     = 64'sd5;
      bus.req_b[0]     = -64'sd7;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
         failures++;
         $display("FAIL sum_ready got=%b exp=01", bus.req_ready);
      end
      next_cycle();
      bus.req_valid = 2'b00;
      next_cycle();
      bus.rsp_ready = 2'b01;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 64'hFFFF_FFFF_FFFF_FFFE || bus.rsp_flags !== 6'b010001) begin
         failures++;
         $display("FAIL sum_resp got=%b/%h/%b exp=01/fffffffffffffffe/010001", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
      end
      next_cycle();
      bus.rsp_ready = 2'b00;
      m_prio = 1;
   endtask

   task automatic test_overflow();
      bus.req_valid    = 2'b10;
      bus.req_funct[1] = 3'd2;
      bus.req_a[1]     = 64'h8000_0000_0000_0000;
      bus.req_b[1]     = 64'd1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10) begin
         failures++;
         $display("FAIL ovf_ready got=%b exp=10", bus.req_ready);
      end
      next_cycle();
      bus.req_valid = 2'b00;
      next_cycle();
      bus.rsp_ready = 2'b10;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 64'h7FFF_FFFF_FFFF_FFFF || bus.rsp_flags !== 6'b100010) begin
         failures++;
         $display("FAIL ovf_resp got=%b/%h/%b exp=10/7fffffffffffffff/100010", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
      end
      next_cycle();
      bus.rsp_ready = 2'b00;
      m_prio = 0;
   endtask

   task automatic test_back_to_back();
      int          cyc;
      int          last_acc;
      int          waited;
      logic [1:0]  exp_rdy;
      logic [69:0] exp_v;
      int          g;
      do_reset();
      cyc      = 0;
      last_acc = -1;
      bus.req_valid    = 2'b11;
      bus.rsp_ready    = 2'b11;
      bus.req_funct[0] = 3'd1;
      bus.req_funct[1] = 3'd4;
      for (int k = 0; k < 4; k++) begin
         bus.req_a[0] = 64'(k * 7 + 1);
         bus.req_b[0] = 64'(k + 100);
         bus.req_a[1] = 64'(k * 13 + 3);
         bus.req_b[1] = 64'hF0F0;
         waited = 0;
         @(negedge clk);
         while (bus.req_ready == 2'b00 && waited < 10) begin
            next_cycle();
            cyc++;
            waited++;
            @(negedge clk);
         end
         g       = k % 2;
         exp_rdy = (g == 0) ? 2'b01 : 2'b10;
         exp_v   = alu_fn(bus.req_funct[g], bus.req_a[g], bus.req_b[g]);
         checks++;
         if (bus.req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL rr_grant%0d got=%b exp=%b waited=%0d", k, bus.req_ready, exp_rdy, waited);
         end
         if (k > 0) begin
            checks++;
            if (cyc - last_acc != 3) begin
               failures++;
               $display("FAIL rr_spacing%0d got=%0d exp=3", k, cyc - last_acc);
            end
         end
         last_acc = cyc;
         next_cycle();
         cyc++;
         next_cycle();
         cyc++;
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== exp_rdy || {bus.rsp_flags, bus.rsp_result} !== exp_v) begin
            failures++;
            $display("FAIL rr_resp%0d got=%b/%h exp=%b/%h", k, bus.rsp_valid, {bus.rsp_flags, bus.rsp_result}, exp_rdy, exp_v);
         end
         next_cycle();
         cyc++;
      end
      idle_inputs();
      m_prio = 0;
   endtask

   task automatic test_backpressure();
      logic [69:0] exp_v;
      do_reset();
      bus.req_valid    = 2'b01;
      bus.req_funct[0] = 3'd3;
      bus.req_a[0]     = 64'hDEAD_BEEF_1234_5678;
      bus.req_b[0]     = 64'hFF00_FF00_FF00_FF00;
      exp_v = alu_fn(3'd3, 64'hDEAD_BEEF_1234_5678, 64'hFF00_FF00_FF00_FF00);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
         failures++;
         $display("FAIL bp_accept got=%b exp=01", bus.req_ready);
      end
      next_cycle();
      bus.req_valid    = 2'b10;
      bus.rsp_ready    = 2'b10;
      bus.req_funct[1] = 3'd5;
      bus.req_a[1]     = 64'd9;
      next_cycle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b00 || {bus.rsp_flags, bus.rsp_result} !== exp_v) begin
            failures++;
            $display("FAIL bp_hold%0d got=%b/%b/%h exp=01/00/%h", i, bus.rsp_valid, bus.req_ready, {bus.rsp_flags, bus.rsp_result}, exp_v);
         end
         next_cycle();
      end
      bus.rsp_ready = 2'b11;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b00) begin
         failures++;
         $display("FAIL bp_release got=%b/%b exp=01/00", bus.rsp_valid, bus.req_ready);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10) begin
         failures++;
         $display("FAIL bp_waiter got=%b exp=10", bus.req_ready);
      end
      next_cycle();
      bus.req_valid = 2'b00;
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== ~64'd9) begin
         failures++;
         $display("FAIL bp_waiter_resp got=%b/%h exp=10/%h", bus.rsp_valid, bus.rsp_result, ~64'd9);
      end
      next_cycle();
      bus.rsp_ready = 2'b00;
      m_prio = 0;
   endtask

   task automatic test_reset_mid_op();
      // Complete a port-0 op so priority sits on port 1 and rsp_result is non-zero
      bus.req_valid    = 2'b01;
      bus.req_funct[0] = 3'd0;
      bus.req_a[0]     = 64'h1234;
      bus.rsp_ready    = 2'b01;
      next_cycle();
      bus.req_valid = 2'b00;
      next_cycle();
      next_cycle();
      bus.rsp_ready    = 2'b00;
      bus.req_valid    = 2'b10;
      bus.req_funct[1] = 3'd6;
      bus.req_a[1]     = 64'd77;
      next_cycle();
      bus.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_exec got=%b exp=1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, bus.rsp_valid, bus.rsp_flags} !== 9'd0 || {bus.rsp_result, alu_a} !== 128'd0) begin
         failures++;
         $display("FAIL mid_reset got=%b/%b/%h/%h exp=0", busy, bus.rsp_valid, bus.rsp_result, alu_a);
      end
      next_cycle();
      rst_n  = 1'b1;
      m_prio = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_noresp%0d got=%b/%b exp=00/0", i, bus.rsp_valid, busy);
         end
         next_cycle();
      end
      bus.req_valid = 2'b11;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
         failures++;
         $display("FAIL mid_prio got=%b exp=01", bus.req_ready);
      end
      idle_inputs();
      do_reset();
   endtask

   task automatic test_idle();
      idle_inputs();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({busy, bus.req_ready, bus.rsp_valid} !== 5'd0) begin
            failures++;
            $display("FAIL idle%0d got=%b exp=00000", i, {busy, bus.req_ready, bus.rsp_valid});
         end
         next_cycle();
      end
   endtask

   task automatic test_random();
      logic        busy_m  = 1'b0;
      int          acc_cyc = 0;
      int          op_port = 0;
      int          g       = 0;
      logic [69:0] exp_v   = '0;
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_rv;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!bus.req_valid[p] && $urandom_range(0, 2) != 0) begin
               bus.req_valid[p] = 1'b1;
               bus.req_funct[p] = 3'($urandom_range(0, 7));
               bus.req_a[p]     = rnd64();
               bus.req_b[p]     = rnd64();
            end
            bus.rsp_ready[p] = ($urandom_range(0, 2) == 0);
         end
         @(negedge clk);
         exp_rdy = 2'b00;
         if (!busy_m && bus.req_valid != 2'b00) begin
            if (bus.req_valid == 2'b01)      g = 0;
            else if (bus.req_valid == 2'b10) g = 1;
            else                             g = m_prio;
            exp_rdy[g] = 1'b1;
         end
         exp_rv = 2'b00;
         if (busy_m && cyc >= acc_cyc + 2) exp_rv[op_port] = 1'b1;
         checks++;
         if (bus.req_ready !== exp_rdy || bus.rsp_valid !== exp_rv || busy !== busy_m) begin
            failures++;
            $display("FAIL rnd_ctrl c%0d got=%b/%b/%b exp=%b/%b/%b", cyc, bus.req_ready, bus.rsp_valid, busy, exp_rdy, exp_rv, busy_m);
         end
         if (exp_rv != 2'b00) begin
            checks++;
            if ({bus.rsp_flags, bus.rsp_result} !== exp_v) begin
               failures++;
               $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, {bus.rsp_flags, bus.rsp_result}, exp_v);
            end
            if (bus.rsp_ready[op_port]) begin
               busy_m = 1'b0;
               m_prio = 1 - op_port;
            end
         end
         if (exp_rdy != 2'b00) begin
            busy_m  = 1'b1;
            acc_cyc = cyc;
            op_port = g;
            exp_v   = alu_fn(bus.req_funct[g], bus.req_a[g], bus.req_b[g]);
         end
         next_cycle();
         if (exp_rdy != 2'b00) bus.req_valid[g] = 1'b0;
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single_op();
      test_overflow();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_op();
      test_idle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, meaning the port that holds priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid[i]  input  1  port i (i=0,1) has an operation pending.
REQ-005 req_ready[i]  output  1  port i operation accepted this cycle.
REQ-006 req_funct[i]  input  3  op code: 0 LOAD, 1 SUM, 2 SUB, 3 AND, 4 XOR, 5 NOT, 6 INC.
REQ-007 req_a[i], req_b[i]  input  64 each  signed operands.
REQ-008 rsp_valid[i]  output  1  result for port i held on rsp_result/rsp_flags.
REQ-009 rsp_ready[i]  input  1  port i consumes its response.
REQ-010 rsp_result  output  64  registered result, shared by both ports.
REQ-011 rsp_flags  output  6  registered {overflow, negative, zero, equal, greater, less}.
REQ-012 alu_funct  output  3, alu_a and alu_b  output  64 each  drive the shared ALU from internal operand registers.
REQ-013 alu_result  input  64, alu_flags  input  6  combinational ALU outputs, same bit order as rsp_flags.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE, when one port alone is valid, that port SHALL be granted; when both are valid, the port holding priority SHALL be granted.
REQ-017 req_ready[g] SHALL be high only in IDLE, only for the granted port g, in the same cycle as req_valid[g]; the other port's ready SHALL be 0.
REQ-018 On acceptance, funct, a, b and the grant index SHALL be latched, and the state SHALL go to EXEC.
REQ-019 In EXEC, alu_* SHALL present the latched values, alu_result/alu_flags SHALL be captured into rsp_result/rsp_flags, and the state SHALL go to RESP.
REQ-020 In RESP, rsp_valid[g] SHALL be high; rsp_result, rsp_flags and rsp_valid SHALL stay stable until rsp_ready[g] is high.
REQ-021 When rsp_valid[g] and rsp_ready[g] are both high, the state SHALL return to IDLE and priority SHALL pass to port 1-g.
REQ-022 rsp_ready on the non-granted port SHALL be ignored.
REQ-023 Latency SHALL be: accept in cycle N, rsp_valid in cycle N+2; peak throughput SHALL be one operation per 3 cycles.
REQ-024 req_ready SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait and SHALL NOT be dropped.
REQ-025 Funct codes 7 SHALL be forwarded unchanged; the result SHALL be whatever the ALU returns (0 from the team ALU).
REQ-026 alu_* outputs SHALL hold the last latched values in IDLE and RESP.
REQ-027 rsp_valid[0] and rsp_valid[1] SHALL never be high together.

Reset
REQ-028 When rst_n is low, the block SHALL immediately enter IDLE and SHALL clear to 0: rsp_valid, rsp_result, rsp_flags, alu_funct, alu_a, alu_b and busy.
REQ-029 On reset, priority SHALL be set to RR_INIT.
REQ-030 A reset in EXEC or RESP SHALL discard the in-flight operation with no response produced.
REQ-031 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-032 Single op: port 0 SUM a=5, b=-7 -> ready0 in N; rsp_valid0 in N+2; result -2; flags negative=1, less=1, others 0.
REQ-033 Overflow: port 1 SUB a=0x8000000000000000, b=1 -> result 0x7FFFFFFFFFFFFFFF; overflow=1, negative=0.
REQ-034 Contention: both ports valid every cycle (RR_INIT=0) -> grants alternate 0,1,0,1; each response is on the correct port.
REQ-035 Backpressure: rsp_ready0 held low 5 cycles -> rsp_valid0 and result stable; port 1 not accepted until the handshake completes.
REQ-036 Reset mid-op: rst_n low during EXEC -> busy=0 and rsp_valid=0 at once; no response follows; priority = RR_INIT.
REQ-037 Idle: no valids for 10 cycles -> busy=0, req_ready=0 on both ports, no rsp_valid.
